memory_bus_mux: RTL and testbench

Parametrised successor to the single-slot memory bus mailbox: multiplexes NUM_SOURCES requesters onto one memory port and routes responses back by BusID. Each source gets a REQ_DEPTH request FIFO, with round-robin arbitration into a registered memory-side request stage. Each source also gets a one-entry response mailbox. Sits between cache/fetch/LSU clients and the memory controller.

---
 rtl/memory_bus_mux.sv | 199 +++++++++++++++++++
 tb/tb_memory_bus_mux.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_mux.sv
// memory_bus_mux: per-source request FIFOs, round-robin onto one memory port,
// responses routed back by BusID into one-entry mailboxes. MEMORY_BUS_STATS_EN adds counters.
module memory_bus_mux #(
  parameter int NUM_SOURCES = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_W        = $clog2(NUM_SOURCES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SOURCES-1:0]        src_req_valid,
  output logic [NUM_SOURCES-1:0]        src_req_ready,
  input  logic [NUM_SOURCES-1:0]        src_req_write,
  input  logic [NUM_SOURCES*ADDR_W-1:0] src_req_addr,
  input  logic [NUM_SOURCES*DATA_W-1:0] src_req_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  output logic [ID_W-1:0]               mem_req_id,
  input  logic                          mem_resp_valid,
  output logic                          mem_resp_ready,
  input  logic [ID_W-1:0]               mem_resp_id,
  input  logic [DATA_W-1:0]             mem_resp_data,
  output logic [NUM_SOURCES-1:0]        src_resp_valid,
  input  logic [NUM_SOURCES-1:0]        src_resp_ready,
  output logic [NUM_SOURCES*DATA_W-1:0] src_resp_data,
  output logic                          bad_id_err
`ifdef MEMORY_BUS_STATS_EN
  ,
  output logic [NUM_SOURCES*32-1:0]     stat_grants,
  output logic [31:0]                   stat_stalls
`endif
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(REQ_DEPTH);
  localparam logic [ID_W:0] NS = (ID_W+1)'(NUM_SOURCES);

  logic              fifo_write [NUM_SOURCES][REQ_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [NUM_SOURCES][REQ_DEPTH];
  logic [DATA_W-1:0] fifo_data  [NUM_SOURCES][REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr     [NUM_SOURCES];
  logic [PTR_W-1:0]  rd_ptr     [NUM_SOURCES];
  logic [PTR_W:0]    count      [NUM_SOURCES];

  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] pop;
  logic [NUM_SOURCES-1:0] nonempty;
  logic [NUM_SOURCES-1:0] fill;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        rr_next;
  logic [ID_W-1:0]        gnt;
  logic                   gnt_valid;
  logic                   load;
  logic                   sel_write;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_data;
  logic                   id_ok;

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      src_req_ready[i] = count[i] != FULL;
      nonempty[i] = count[i] != '0;
    end
  end

  assign push = src_req_valid & src_req_ready;
  assign load = !mem_req_valid || mem_req_ready;

  // Scan from rr_ptr upward with wrap; first non-empty FIFO wins.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    gnt_valid = 1'b0;
    rr_next = rr_ptr;
    sel_write = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      for (int j = 0; j < NUM_SOURCES; j++) begin
        if (!gnt_valid && j == idx && nonempty[j]) begin
          gnt_valid = 1'b1;
          gnt = ID_W'(j);
          rr_next = (j == NUM_SOURCES - 1) ? '0 : ID_W'(j + 1);
          sel_write = fifo_write[j][rd_ptr[j]];
          sel_addr = fifo_addr[j][rd_ptr[j]];
          sel_data = fifo_data[j][rd_ptr[j]];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++)
      pop[i] = load && gnt_valid && gnt == ID_W'(i);
  end

  // Storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (push[i]) begin
        fifo_write[i][wr_ptr[i]] <= src_req_write[i];
        fifo_addr[i][wr_ptr[i]] <= src_req_addr[i*ADDR_W +: ADDR_W];
        fifo_data[i][wr_ptr[i]] <= src_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i]) count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_id <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      mem_req_valid <= gnt_valid;
      if (gnt_valid) begin
        mem_req_write <= sel_write;
        mem_req_addr <= sel_addr;
        mem_req_data <= sel_data;
        mem_req_id <= gnt;
        rr_ptr <= rr_next;
      end
    end
  end

  // Out-of-range ids are always accepted so a bad response never wedges memory.
  always_comb begin
    id_ok = {1'b0, mem_resp_id} < NS;
    mem_resp_ready = !id_ok;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (mem_resp_id == ID_W'(i))
        mem_resp_ready = !src_resp_valid[i] || src_resp_ready[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++)
      fill[i] = mem_resp_valid && mem_resp_ready && mem_resp_id == ID_W'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_resp_valid <= '0;
      src_resp_data <= '0;
      bad_id_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (fill[i]) begin
          src_resp_valid[i] <= 1'b1;
          src_resp_data[i*DATA_W +: DATA_W] <= mem_resp_data;
        end else if (src_resp_ready[i]) begin
          src_resp_valid[i] <= 1'b0;
        end
      end
      if (mem_resp_valid && !id_ok) bad_id_err <= 1'b1;
    end
  end

`ifdef MEMORY_BUS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (pop[i]) stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
      if (mem_req_valid && !mem_req_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_bus_mux.sv
// Bench for memory_bus_mux: directed scenarios plus random traffic,
// scoreboarded by a per-source queue / mailbox reference model.
module tb_memory_bus_mux;

  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    src_req_valid = '0;
  logic [N-1:0]    src_req_ready;
  logic [N-1:0]    src_req_write = '0;
  logic [N*AW-1:0] src_req_addr = '0;
  logic [N*DW-1:0] src_req_data = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [IW-1:0]   mem_req_id;
  logic            mem_resp_valid = 1'b0;
  logic            mem_resp_ready;
  logic [IW-1:0]   mem_resp_id = '0;
  logic [DW-1:0]   mem_resp_data = '0;
  logic [N-1:0]    src_resp_valid;
  logic [N-1:0]    src_resp_ready = '0;
  logic [N*DW-1:0] src_resp_data;
  logic            bad_id_err;
`ifdef MEMORY_BUS_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_stalls;
`endif

  memory_bus_mux #(
    .NUM_SOURCES(N), .REQ_DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .src_req_valid(src_req_valid), .src_req_ready(src_req_ready),
    .src_req_write(src_req_write), .src_req_addr(src_req_addr),
    .src_req_data(src_req_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_id(mem_resp_id), .mem_resp_data(mem_resp_data),
    .src_resp_valid(src_resp_valid), .src_resp_ready(src_resp_ready),
    .src_resp_data(src_resp_data), .bad_id_err(bad_id_err)
`ifdef MEMORY_BUS_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    int id;
    int cyc;
  } grant_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  req_t          req_q [N][$];
  grant_t        glog[$];
  logic          exp_full [N];
  logic [DW-1:0] exp_data [N];
  logic          exp_bad;
  logic          hold;
  req_t          held;
  int            held_id;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    src_req_write[i] = w;
    src_req_addr[i*AW +: AW] = a;
    src_req_data[i*DW +: DW] = d;
  endtask

  // Monitor: inputs change just after posedge, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        req_q[i].delete();
        exp_full[i] = 1'b0;
        exp_data[i] = '0;
      end
      exp_bad = 1'b0;
      hold = 1'b0;
    end else begin
      logic exp_rdy;
      cyc++;
      if (hold) begin
        chk("stage_hold_valid", {127'd0, mem_req_valid}, 128'd1);
        chk("stage_hold_pkt", {mem_req_write, mem_req_addr, mem_req_data}, held);
        chk("stage_hold_id", {125'd0, mem_req_id}, 128'(held_id));
      end
      if (mem_req_valid && mem_req_ready) begin
        int id;
        id = int'(mem_req_id);
        glog.push_back('{id, cyc});
        if (id >= N) begin
          chk("grant_id_range", 128'(id), 128'(N - 1));
        end else if (req_q[id].size() == 0) begin
          chk("unexpected_req", 128'(id), 128'hFFFF);
        end else begin
          req_t e;
          e = req_q[id].pop_front();
          chk("mem_req_pkt", {mem_req_write, mem_req_addr, mem_req_data}, e);
        end
      end
      hold = mem_req_valid && !mem_req_ready;
      held = {mem_req_write, mem_req_addr, mem_req_data};
      held_id = int'(mem_req_id);
      for (int i = 0; i < N; i++) begin
        if (src_req_valid[i] && src_req_ready[i])
          req_q[i].push_back({src_req_write[i], src_req_addr[i*AW +: AW],
                              src_req_data[i*DW +: DW]});
      end
      if (int'(mem_resp_id) >= N) exp_rdy = 1'b1;
      else exp_rdy = !exp_full[mem_resp_id] || src_resp_ready[mem_resp_id];
      chk("mem_resp_ready", {127'd0, mem_resp_ready}, {127'd0, exp_rdy});
      chk("bad_id_err", {127'd0, bad_id_err}, {127'd0, exp_bad});
      for (int i = 0; i < N; i++) begin
        chk("src_resp_valid", {127'd0, src_resp_valid[i]}, {127'd0, exp_full[i]});
        if (exp_full[i] && src_resp_ready[i]) begin
          chk("src_resp_data", {64'd0, src_resp_data[i*DW +: DW]}, {64'd0, exp_data[i]});
          exp_full[i] = 1'b0;
        end
      end
      if (mem_resp_valid && exp_rdy) begin
        if (int'(mem_resp_id) < N) begin
          exp_full[mem_resp_id] = 1'b1;
          exp_data[mem_resp_id] = mem_resp_data;
        end else begin
          exp_bad = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int ones;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req_valid", {127'd0, mem_req_valid}, 128'd0);
    chk("rst_src_req_ready", {124'd0, src_req_ready}, 128'hF);
    chk("rst_src_resp_valid", {124'd0, src_resp_valid}, 128'd0);
    chk("rst_mem_req_addr", {96'd0, mem_req_addr}, 128'd0);
    chk("rst_src_resp_data", src_resp_data[127:0], 128'd0);
    chk("rst_bad_id", {127'd0, bad_id_err}, 128'd0);

    // Single read from src 2: visible two cycles after presentation
    tick();
    src_req_valid = 4'b0100;
    set_req(2, 1'b0, 32'h100, 64'h0);
    tick();
    src_req_valid = '0;
    @(negedge clk);
    chk("lat_early", {127'd0, mem_req_valid}, 128'd0);
    tick();
    @(negedge clk);
    chk("lat_valid", {127'd0, mem_req_valid}, 128'd1);
    chk("lat_id", {125'd0, mem_req_id}, 128'd2);
    chk("lat_write", {127'd0, mem_req_write}, 128'd0);
    chk("lat_addr", {96'd0, mem_req_addr}, 128'h100);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;

    // Two backlog rounds from rr_ptr=0
    do_reset();
    mem_req_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      glog.delete();
      src_req_valid = 4'hF;
      for (int i = 0; i < N; i++) set_req(i, i[0], 32'h1000 + 32'(r*16 + i), 64'(i * 7 + r));
      tick();
      src_req_valid = '0;
      repeat (8) tick();
      chk("rr_count", 128'(glog.size()), 128'd4);
      for (int i = 0; i < N && i < glog.size(); i++) begin
        chk("rr_order", 128'(glog[i].id), 128'(i));
        if (i > 0) chk("rr_back2back", 128'(glog[i].cyc - glog[i-1].cyc), 128'd1);
      end
    end

    // Src 1 backpressure: 4 FIFO entries + 1 in stage
    mem_req_ready = 1'b0;
    glog.delete();
    acc = 0;
    for (int g = 0; g < 20 && acc < 5; g++) begin
      src_req_valid = 4'b0010;
      set_req(1, 1'b1, 32'h200 + 32'(acc), 64'hA0 + 64'(acc));
      @(negedge clk);
      if (src_req_ready[1]) acc++;
      tick();
    end
    chk("bp_accepted", 128'(acc), 128'd5);
    set_req(1, 1'b1, 32'h2FF, 64'hFF);
    @(negedge clk);
    chk("bp_ready_low", {127'd0, src_req_ready[1]}, 128'd0);
    tick();
    @(negedge clk);
    chk("bp_ready_still_low", {127'd0, src_req_ready[1]}, 128'd0);
    chk("bp_stage_head", {96'd0, mem_req_addr}, 128'h200);
    src_req_valid = '0;
    tick();
    mem_req_ready = 1'b1;
    repeat (10) tick();
    ones = 0;
    foreach (glog[k]) if (glog[k].id == 1) ones++;
    chk("bp_drained", 128'(ones), 128'd5);
    chk("bp_queue_empty", 128'(req_q[1].size()), 128'd0);
    mem_req_ready = 1'b0;

    // Response to id 3, then a second one that must wait for the drain
    mem_resp_valid = 1'b1;
    mem_resp_id = 3'd3;
    mem_resp_data = 64'hDEADBEEF;
    @(negedge clk);
    chk("resp1_ready", {127'd0, mem_resp_ready}, 128'd1);
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("resp1_valid", {127'd0, src_resp_valid[3]}, 128'd1);
    chk("resp1_data", {64'd0, src_resp_data[3*DW +: DW]}, 128'hDEADBEEF);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'h12345678_9ABCDEF0;
    @(negedge clk);
    chk("resp2_blocked", {127'd0, mem_resp_ready}, 128'd0);
    tick();
    @(negedge clk);
    chk("resp2_blocked2", {127'd0, mem_resp_ready}, 128'd0);
    chk("resp2_old_data", {64'd0, src_resp_data[3*DW +: DW]}, 128'hDEADBEEF);
    tick();
    src_resp_ready = 4'b1000;
    @(negedge clk);
    chk("resp2_refill_ready", {127'd0, mem_resp_ready}, 128'd1);
    tick();
    mem_resp_valid = 1'b0;
    src_resp_ready = '0;
    @(negedge clk);
    chk("resp2_valid", {127'd0, src_resp_valid[3]}, 128'd1);
    chk("resp2_data", {64'd0, src_resp_data[3*DW +: DW]}, 128'h12345678_9ABCDEF0);
    tick();
    src_resp_ready = 4'b1000;
    tick();
    src_resp_ready = '0;
    @(negedge clk);
    chk("resp_drained", {124'd0, src_resp_valid}, 128'd0);

    // Out-of-range id 5
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_id = 3'd5;
    mem_resp_data = 64'h55;
    @(negedge clk);
    chk("bad_ready", {127'd0, mem_resp_ready}, 128'd1);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_id = 3'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("bad_sticky", {127'd0, bad_id_err}, 128'd1);
    chk("bad_no_mailbox", {124'd0, src_resp_valid}, 128'd0);

    // Reset mid-operation
    src_req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 32'h300 + 32'(i), 64'(i));
    tick();
    tick();
    src_req_valid = '0;
    mem_resp_valid = 1'b1;
    mem_resp_id = 3'd0;
    mem_resp_data = 64'hA;
    tick();
    mem_resp_id = 3'd1;
    mem_resp_data = 64'hB;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_id = 3'd0;
    @(negedge clk);
    chk("pre_rst_mailboxes", {124'd0, src_resp_valid}, 128'h3);
    chk("pre_rst_stage", {127'd0, mem_req_valid}, 128'd1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_stage", {127'd0, mem_req_valid}, 128'd0);
    chk("mid_rst_mailboxes", {124'd0, src_resp_valid}, 128'd0);
    chk("mid_rst_ready", {124'd0, src_req_ready}, 128'hF);
    chk("mid_rst_bad", {127'd0, bad_id_err}, 128'd0);
`ifdef MEMORY_BUS_STATS_EN
    chk("mid_rst_stalls", {96'd0, stat_stalls}, 128'd0);
    chk("mid_rst_grants", stat_grants, 128'd0);
`endif
    // Nothing from before the reset may leak; rr_ptr back at 0 picks src 1 before 3
    glog.delete();
    mem_req_ready = 1'b1;
    src_req_valid = 4'b1010;
    set_req(1, 1'b0, 32'h401, 64'h1);
    set_req(3, 1'b0, 32'h403, 64'h3);
    tick();
    src_req_valid = '0;
    repeat (6) tick();
    chk("post_rst_count", 128'(glog.size()), 128'd2);
    if (glog.size() >= 2) begin
      chk("post_rst_first", 128'(glog[0].id), 128'd1);
      chk("post_rst_second", 128'(glog[1].id), 128'd3);
    end

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      src_req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom), $urandom, {$urandom, $urandom});
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_resp_valid = 1'($urandom);
      mem_resp_id = ($urandom_range(0, 19) == 0) ? 3'(4 + $urandom_range(0, 3))
                                                 : 3'($urandom_range(0, N - 1));
      mem_resp_data = {$urandom, $urandom};
      src_resp_ready = N'($urandom);
      tick();
    end

    // Drain everything still queued
    src_req_valid = '0;
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    src_resp_ready = '1;
    begin
      int left;
      left = 1;
      for (int g = 0; g < 100 && left != 0; g++) begin
        tick();
        @(negedge clk);
        left = 0;
        for (int i = 0; i < N; i++) left += req_q[i].size();
      end
      chk("drain_left", 128'(left), 128'd0);
    end
    tick();
    @(negedge clk);
    chk("drain_idle", {127'd0, mem_req_valid}, 128'd0);
    chk("drain_mailboxes", {124'd0, src_resp_valid}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
